// File: rtl/dmem_dump_reader_if.sv
// ============================================================================
// Module      : dmem_dump_reader_if
// Description : Bus bundle for the data-memory dump reader. Carries the
//               synchronous read port towards the data memory and the
//               valid/ready word stream towards the consumer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_dump_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
);
   // Data-memory read port (the memory returns data one cycle after the strobe)
   logic                  memReadEnable;
   logic [ADDR_WIDTH-1:0] memAddress;
   logic [DATA_WIDTH-1:0] memData;

   // Streamed word towards the consumer
   logic [DATA_WIDTH-1:0] outData;
   logic [ADDR_WIDTH-1:0] outAddress;
   logic                  outValid;
   logic                  outReady;

   // Reader side: drives the read strobe/address and the outgoing stream
   modport master (
      output memReadEnable,
      output memAddress,
      input  memData,
      output outData,
      output outAddress,
      output outValid,
      input  outReady
   );

   // Memory/consumer side: returns read data and accepts the stream
   modport slave (
      input  memReadEnable,
      input  memAddress,
      output memData,
      input  outData,
      input  outAddress,
      input  outValid,
      output outReady
   );
endinterface

`default_nettype wire

// File: rtl/dmem_dump_reader.sv
// ============================================================================
// Module      : dmem_dump_reader
// Description : Readback engine for the 128-word data memory. On a start
//               pulse it reads a contiguous (wrapping) run of words through
//               the synchronous read port and streams each word with its
//               address over a valid/ready handshake. One word every three
//               cycles when the consumer is always ready.
// Options     : DMEM_DUMP_CHECKSUM_EN - adds an XOR checksum output of all
//               words streamed in the current dump.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_dump_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 7
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  start,
   input  wire logic [ADDR_WIDTH-1:0] startAddress,
   input  wire logic [ADDR_WIDTH:0]   wordCount,
   output logic                       busy,
   output logic                       done,
   dmem_dump_reader_if.master         bus
`ifdef DMEM_DUMP_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]      checksum
`endif
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_HOLD    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;     // address of the word in flight
   logic [ADDR_WIDTH:0]   remaining;    // words still to be handed over

   logic                  handshake;
   logic                  last_word;
   logic [ADDR_WIDTH-1:0] next_addr;

   // Handshake detection and next-address arithmetic (wraps naturally at 2**ADDR_WIDTH)
   always_comb begin
      handshake = bus.outValid & bus.outReady;
      last_word = (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1});
      next_addr = cur_addr + 1'b1;
   end

   // Dump sequencer: every output is registered and updated on state entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= S_IDLE;
         busy              <= 1'b0;
         done              <= 1'b0;
         cur_addr          <= '0;
         remaining         <= '0;
         bus.memReadEnable <= 1'b0;
         bus.memAddress    <= '0;
         bus.outData       <= '0;
         bus.outAddress    <= '0;
         bus.outValid      <= 1'b0;
`ifdef DMEM_DUMP_CHECKSUM_EN
         checksum          <= '0;
`endif
      end else begin
         // done is a single-cycle pulse raised only on entry to S_DONE
         done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  cur_addr  <= startAddress;
                  remaining <= wordCount;
                  busy      <= 1'b1;
`ifdef DMEM_DUMP_CHECKSUM_EN
                  checksum  <= '0;
`endif
                  if (wordCount == '0) begin
                     // Empty dump: straight to the done cycle, no memory access
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state             <= S_ISSUE;
                     bus.memReadEnable <= 1'b1;
                     bus.memAddress    <= startAddress;
                  end
               end
            end

            S_ISSUE: begin
               // Read strobe was presented for exactly this cycle
               bus.memReadEnable <= 1'b0;
               state             <= S_CAPTURE;
            end

            S_CAPTURE: begin
               // memData is valid now, one cycle after the strobe edge
               bus.outData    <= bus.memData;
               bus.outAddress <= cur_addr;
               bus.outValid   <= 1'b1;
               state          <= S_HOLD;
            end

            S_HOLD: begin
               // Word and address stay frozen until the consumer takes them
               if (handshake) begin
                  bus.outValid <= 1'b0;
                  remaining    <= remaining - 1'b1;
                  cur_addr     <= next_addr;
`ifdef DMEM_DUMP_CHECKSUM_EN
                  checksum     <= checksum ^ bus.outData;
`endif
                  if (last_word) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state             <= S_ISSUE;
                     bus.memReadEnable <= 1'b1;
                     bus.memAddress    <= next_addr;
                  end
               end
            end

            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state             <= S_IDLE;
               busy              <= 1'b0;
               bus.memReadEnable <= 1'b0;
               bus.outValid      <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
